// File: rtl/uart_tx_queue.sv
// Buffered CPU front-end for uart_t: a byte FIFO plus a sequencer that feeds uart_t one byte at
// a time, polls its busy flag between bytes and defers divisor updates until uart_t is idle.
module uart_tx_queue #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned DIV_RESET  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_wen,
   input  logic [7:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        u_wen,
   output logic [31:0] u_addr,
   output logic [31:0] u_wdata,
   input  logic [31:0] u_rdata
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

   localparam logic [7:0] BusData = 8'h00;
   localparam logic [7:0] BusDiv  = 8'h04;
   localparam logic [7:0] BusStat = 8'h08;
   localparam logic [7:0] BusLvl  = 8'h0C;

   localparam logic [31:0] UData = 32'h0000_0000;
   localparam logic [31:0] UDiv  = 32'h0000_0004;
   localparam logic [31:0] UBusy = 32'h0000_0008;

   typedef enum logic [2:0] {
      StIdle,
      StCfg,
      StSend,
      StPoll,
      StCheck
   } state_e;

   state_e                state_q;
   logic [7:0]            mem_q [Depth];
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic [31:0]           shadow_q;
   logic                  cfg_pend_q;
   logic                  ovf_q;

   logic empty;
   logic full;
   logic busy;
   logic pop;
   logic push_req;
   logic push_ok;
   logic div_wr;
   logic ovf_clr;

   // Only the busy flag of uart_t's read data matters here.
   logic unused_rdata;
   assign unused_rdata = ^u_rdata[31:1];

   assign empty    = (level_q == '0);
   assign full     = (level_q == LevelFull);
   assign busy     = (state_q != StIdle) | !empty | cfg_pend_q;
   assign pop      = (state_q == StSend);
   assign push_req = bus_wen && (bus_addr == BusData);
   // A push on a full FIFO still fits when the head leaves in the same cycle.
   assign push_ok  = push_req && !reset && (!full || pop);
   assign div_wr   = bus_wen && (bus_addr == BusDiv);
   assign ovf_clr  = bus_wen && (bus_addr == BusLvl);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= bus_wdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // uart_t has no reset, so start by polling it and reprogram the divisor once it is idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StPoll;
         u_wen      <= 1'b0;
         u_addr     <= UBusy;
         u_wdata    <= '0;
         shadow_q   <= DIV_RESET;
         cfg_pend_q <= 1'b1;
      end else begin
         u_wen   <= 1'b0;
         u_addr  <= UBusy;
         u_wdata <= '0;
         case (state_q)
            StIdle: begin
               if (cfg_pend_q) begin
                  state_q <= StCfg;
                  u_wen   <= 1'b1;
                  u_addr  <= UDiv;
                  u_wdata <= shadow_q;
               end else if (!empty) begin
                  state_q <= StSend;
                  u_wen   <= 1'b1;
                  u_addr  <= UData;
                  u_wdata <= {24'h0, mem_q[rd_ptr_q]};
               end
            end
            StCfg: begin
               cfg_pend_q <= 1'b0;
               state_q    <= StIdle;
            end
            StSend:  state_q <= StPoll;
            StPoll:  state_q <= StCheck;
            StCheck: state_q <= u_rdata[0] ? StPoll : StIdle;
            default: state_q <= StIdle;
         endcase
         // A new divisor wins over a CFG issued in the same cycle; it is sent again later.
         if (div_wr) begin
            shadow_q   <= bus_wdata;
            cfg_pend_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q     <= 1'b0;
         bus_rdata <= '0;
      end else begin
         if (push_req && !push_ok) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
         if (!bus_wen) begin
            case (bus_addr)
               BusDiv:  bus_rdata <= shadow_q;
               BusStat: bus_rdata <= {28'h0, ovf_q, full, empty, busy};
               BusLvl:  bus_rdata <= 32'(level_q);
               default: bus_rdata <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboarded bench for uart_tx_queue: every write the DUT makes to the uart_t model is popped
// from a queue of expected {addr, data} pairs filled as the stimulus is driven.
module tb_uart_tx_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_wen;
   logic [7:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        u_wen;
   logic [31:0] u_addr;
   logic [31:0] u_wdata;
   logic [31:0] u_rdata;
   logic        uart_busy;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [39:0] expq[$];
   logic [39:0] exp_w;

   always #5 clk = ~clk;

   uart_tx_queue #(
      .DEPTH_LOG2(4),
      .DIV_RESET (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus_wen  (bus_wen),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .u_wen    (u_wen),
      .u_addr   (u_addr),
      .u_wdata  (u_wdata),
      .u_rdata  (u_rdata)
   );

   // uart_t model: registered busy flag at offset 0x08
   always @(posedge clk) begin
      u_rdata <= (u_addr[7:0] == 8'h08) ? {31'h0, uart_busy} : 32'h0;
   end

   // Scoreboard: writes must arrive in order and never while the uart model is busy.
   always @(negedge clk) begin
      #1;
      if (!reset && u_wen) begin
         n_checks++;
         if (expq.size() == 0) begin
            $display("FAIL uart_write: got addr=%h data=%h, required no write", u_addr, u_wdata);
         end else begin
            exp_w = expq.pop_front();
            if (u_addr !== {24'h0, exp_w[39:32]} || u_wdata !== exp_w[31:0] || uart_busy !== 1'b0)
               $display("FAIL uart_write: got addr=%h data=%h busy=%b, required addr=%h data=%h busy=0",
                        u_addr, u_wdata, uart_busy, {24'h0, exp_w[39:32]}, exp_w[31:0]);
            else
               n_pass++;
         end
      end
   end

   task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
      bus_wen   = 1'b1;
      bus_addr  = addr;
      bus_wdata = data;
      @(negedge clk);
      bus_wen  = 1'b0;
      bus_addr = 8'h08;
   endtask

   task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
      bus_wen  = 1'b0;
      bus_addr = addr;
      @(negedge clk);
      data = bus_rdata;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accepted);
      if (accepted) expq.push_back({8'h00, 24'h0, b});
      bus_write(8'h00, {24'h0, b});
   endtask

   task automatic cfg_write(input logic [31:0] div);
      expq.push_back({8'h04, div});
      bus_write(8'h04, div);
   endtask

   // Returns at the falling edge inside the SEND cycle.
   task automatic wait_send(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (u_wen && u_addr == 32'h0) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) $display("FAIL %s: got no SEND within 40 cycles, required a SEND", name);
      else n_pass++;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200; i++) begin
         if (expq.size() == 0) break;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (expq.size() != 0)
         $display("FAIL %s: got %0d writes outstanding, required 0", name, expq.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      bit seen = 1'b0;
      reset     = 1'b1;
      uart_busy = 1'b0;
      bus_wen   = 1'b1;
      bus_addr  = 8'h00;
      bus_wdata = 32'h55;
      repeat (3) @(negedge clk);
      n_checks++;
      if (u_wen !== 1'b0 || u_addr !== 32'h8 || u_wdata !== 32'h0 || bus_rdata !== 32'h0)
         $display("FAIL reset_outputs: got wen=%b addr=%h wdata=%h rdata=%h, required 0/8/0/0",
                  u_wen, u_addr, u_wdata, bus_rdata);
      else n_pass++;
      bus_wen  = 1'b0;
      bus_addr = 8'h08;
      expq.push_back({8'h04, 32'd1});
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (u_wen) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen || u_addr !== 32'h4 || u_wdata !== 32'h1)
         $display("FAIL reset_cfg: got seen=%b addr=%h wdata=%h, required 1/4/1",
                  seen, u_addr, u_wdata);
      else n_pass++;
      wait_drain("reset_drain");
      bus_read(8'h08, rd);
      n_checks++;
      if (rd !== 32'h2) $display("FAIL reset_status: got %h, required 2", rd);
      else n_pass++;
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'h0) $display("FAIL reset_push_ignored: got level %0d, required 0", rd);
      else n_pass++;
   endtask

   task automatic test_in_order();
      logic [31:0] rd;
      cfg_write(32'd2);
      push_byte(8'h41, 1'b1);
      push_byte(8'h42, 1'b1);
      push_byte(8'h43, 1'b1);
      // Read registers the level before the first SEND pops.
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'd3) $display("FAIL order_level: got %0d, required 3", rd);
      else n_pass++;
      wait_drain("order_drain");
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'd0) $display("FAIL order_level_end: got %0d, required 0", rd);
      else n_pass++;
      bus_read(8'h08, rd);
      n_checks++;
      if (rd !== 32'h2) $display("FAIL order_status: got %h, required 2", rd);
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      push_byte(8'h10, 1'b1);
      wait_send("ovf_first_send");
      @(negedge clk);
      uart_busy = 1'b1;
      for (int i = 0; i < 17; i++) push_byte(8'(8'h20 + i), i < 16);
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'd16) $display("FAIL ovf_level: got %0d, required 16", rd);
      else n_pass++;
      bus_read(8'h08, rd);
      n_checks++;
      if (rd !== 32'hD) $display("FAIL ovf_status: got %h, required D", rd);
      else n_pass++;
      bus_read(8'h04, rd);
      n_checks++;
      if (rd !== 32'd2) $display("FAIL ovf_shadow: got %h, required 2", rd);
      else n_pass++;
      bus_write(8'h0C, 32'h0);
      bus_read(8'h08, rd);
      n_checks++;
      if (rd !== 32'h5) $display("FAIL ovf_clear: got %h, required 5", rd);
      else n_pass++;
      uart_busy = 1'b0;
      wait_drain("ovf_drain");
      bus_read(8'h08, rd);
      n_checks++;
      if (rd !== 32'h2) $display("FAIL ovf_status_end: got %h, required 2", rd);
      else n_pass++;
   endtask

   task automatic test_deferred_cfg();
      logic [31:0] rd;
      bit bad = 1'b0;
      push_byte(8'h51, 1'b1);
      wait_send("defer_first_send");
      @(negedge clk);
      uart_busy = 1'b1;
      cfg_write(32'd5);
      push_byte(8'h52, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (u_wen) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL defer_hold: got a uart write while busy, required none");
      else n_pass++;
      uart_busy = 1'b0;
      wait_drain("defer_drain");
      bus_read(8'h04, rd);
      n_checks++;
      if (rd !== 32'd5) $display("FAIL defer_shadow: got %0d, required 5", rd);
      else n_pass++;
   endtask

   task automatic test_reset_mid_byte();
      logic [31:0] rd;
      bit bad = 1'b0;
      push_byte(8'h61, 1'b1);
      wait_send("rst_first_send");
      @(negedge clk);
      uart_busy = 1'b1;
      push_byte(8'h62, 1'b0);
      reset = 1'b1;
      push_byte(8'h63, 1'b0);
      @(negedge clk);
      expq.delete();
      expq.push_back({8'h04, 32'd1});
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (u_wen || u_addr !== 32'h8) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL rst_hold: got a uart write during 50 busy cycles, required none");
      else n_pass++;
      uart_busy = 1'b0;
      wait_drain("rst_drain");
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'd0) $display("FAIL rst_level: got %0d, required 0", rd);
      else n_pass++;
      bus_read(8'h04, rd);
      n_checks++;
      if (rd !== 32'd1) $display("FAIL rst_shadow: got %0d, required 1", rd);
      else n_pass++;
   endtask

   task automatic test_full_pop();
      logic [31:0] rd;
      push_byte(8'h70, 1'b1);
      wait_send("full_first_send");
      @(negedge clk);
      uart_busy = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h71 + i), 1'b1);
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'd16) $display("FAIL full_level: got %0d, required 16", rd);
      else n_pass++;
      uart_busy = 1'b0;
      wait_send("full_send");
      push_byte(8'h99, 1'b1);
      uart_busy = 1'b1;
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'd16) $display("FAIL full_pop_level: got %0d, required 16", rd);
      else n_pass++;
      bus_read(8'h08, rd);
      n_checks++;
      if (rd !== 32'h5) $display("FAIL full_pop_status: got %h, required 5", rd);
      else n_pass++;
      uart_busy = 1'b0;
      wait_drain("full_drain");
      bus_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'd0) $display("FAIL full_level_end: got %0d, required 0", rd);
      else n_pass++;
   endtask

   initial begin
      reset     = 1'b1;
      bus_wen   = 1'b0;
      bus_addr  = 8'h08;
      bus_wdata = 32'h0;
      uart_busy = 1'b0;
      @(negedge clk);
      test_reset();
      test_in_order();
      test_overflow();
      test_deferred_cfg();
      test_reset_mid_byte();
      test_full_pop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
